// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage definitions (state encodings, reset and stall levels).
package if_stage_pkg;
    typedef enum logic [1:0] {
        IF_IDLE  = 2'b00,
        IF_FETCH = 2'b01,
        IF_DRAIN = 2'b10,
        IF_HOLD  = 2'b11
    } if_state_e;
    localparam logic RST_ENABLE = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam int   STALL_IF   = 1;
endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: fetch request/response bus between the fetch stage and the memory controller.
interface if_stage_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              if_req_o;
    logic [ADDR_W-1:0] if_addr_o;
    logic              mem_ready_i;
    logic [INST_W-1:0] mem_inst_i;
    modport master (output if_req_o, output if_addr_o, input mem_ready_i, input mem_inst_i);
    modport slave  (input if_req_o, input if_addr_o, output mem_ready_i, output mem_inst_i);
endinterface

// File: rtl/if_stage.sv
// if_stage: owns the PC, runs the memory fetch handshake and presents instructions to IF/ID.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    if_stage_if.master        mem,
    output logic              get_inst,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst
);
    if_state_e         state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, req_addr, req_n, if_pc_n, target;
    logic [INST_W-1:0] if_inst_n;
    logic              unused_bits;

    assign unused_bits   = ^{stall[5:2], stall[0], branch_target_i[1:0]};
    assign target        = {branch_target_i[ADDR_W-1:2], 2'b00};
    assign mem.if_req_o  = (state == IF_FETCH) || (state == IF_DRAIN);
    assign mem.if_addr_o = req_addr;
    assign get_inst      = state == IF_HOLD;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state    <= IF_IDLE;
            pc       <= ADDR_W'(RESET_PC);
            req_addr <= ADDR_W'(RESET_PC);
            if_pc    <= '0;
            if_inst  <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            req_addr <= req_n;
            if_pc    <= if_pc_n;
            if_inst  <= if_inst_n;
        end
    end

    // A redirect always wins; in-flight requests cannot be aborted, so FETCH without ready drains first.
    always_comb begin
        state_n   = state;
        pc_n      = pc;
        req_n     = req_addr;
        if_pc_n   = if_pc;
        if_inst_n = if_inst;
        case (state)
            IF_IDLE: begin
                state_n = IF_FETCH;
                pc_n    = branch_flag_i ? target : pc;
                req_n   = branch_flag_i ? target : pc;
            end
            IF_FETCH: begin
                if (branch_flag_i) begin
                    pc_n    = target;
                    req_n   = mem.mem_ready_i ? target : req_addr;
                    state_n = mem.mem_ready_i ? IF_FETCH : IF_DRAIN;
                end else if (mem.mem_ready_i) begin
                    if_inst_n = mem.mem_inst_i;
                    if_pc_n   = req_addr;
                    pc_n      = req_addr + ADDR_W'(4);
                    state_n   = IF_HOLD;
                end
            end
            IF_DRAIN: begin
                pc_n = branch_flag_i ? target : pc;
                if (mem.mem_ready_i) begin
                    req_n   = branch_flag_i ? target : pc;
                    state_n = IF_FETCH;
                end
            end
            default: begin
                if (branch_flag_i) begin
                    pc_n    = target;
                    req_n   = target;
                    state_n = IF_FETCH;
                end else if (stall[STALL_IF] == NO_STOP) begin
                    req_n   = pc;
                    state_n = IF_FETCH;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scenario tests for the instruction-fetch stage.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        get_inst;
    logic [31:0] if_pc, if_inst;
    int          errors = 0;
    int          checks = 0;

    if_stage_if #(.ADDR_W(32), .INST_W(32)) mem ();

    if_stage #(.RESET_PC(32'h0), .ADDR_W(32), .INST_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
        .mem(mem.master), .get_inst(get_inst), .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_pulse(input logic [31:0] data);
        mem.mem_ready_i = 1'b1;
        mem.mem_inst_i  = data;
        step();
        mem.mem_ready_i = 1'b0;
        mem.mem_inst_i  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if ({mem.if_req_o, get_inst, if_pc, if_inst} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: req=%b get=%b pc=%h inst=%h, want 0 0 0 0", mem.if_req_o, get_inst, if_pc, if_inst);
        end
        rst = 1'b1;
        checks++;
        if (mem.if_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: req=%b want 0", mem.if_req_o);
        end
        step();
        checks++;
        if ({mem.if_req_o, mem.if_addr_o} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL first_req: req=%b addr=%h want 1 00000000", mem.if_req_o, mem.if_addr_o);
        end
    endtask

    task automatic test_fetch();
        step();
        step();
        mem_pulse(32'h0050_0093);
        checks++;
        if ({get_inst, if_pc, if_inst, mem.if_req_o} !== {1'b1, 32'h0, 32'h0050_0093, 1'b0}) begin
            errors++;
            $display("FAIL fetch_present: get=%b pc=%h inst=%h req=%b want 1 00000000 00500093 0", get_inst, if_pc, if_inst, mem.if_req_o);
        end
        step();
        checks++;
        if ({mem.if_req_o, mem.if_addr_o, get_inst} !== {1'b1, 32'h4, 1'b0}) begin
            errors++;
            $display("FAIL fetch_next: req=%b addr=%h get=%b want 1 00000004 0", mem.if_req_o, mem.if_addr_o, get_inst);
        end
    endtask

    task automatic test_stall();
        mem_pulse(32'h0000_0013);
        stall = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            mem.mem_ready_i = (i == 2);
            mem.mem_inst_i  = 32'hBAD0_BAD0;
            step();
            mem.mem_ready_i = 1'b0;
            checks++;
            if ({get_inst, if_pc, if_inst, mem.if_req_o} !== {1'b1, 32'h4, 32'h0000_0013, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: get=%b pc=%h inst=%h req=%b want 1 00000004 00000013 0", i, get_inst, if_pc, if_inst, mem.if_req_o);
            end
        end
        stall = '0;
        step();
        checks++;
        if ({mem.if_req_o, mem.if_addr_o} !== {1'b1, 32'h8}) begin
            errors++;
            $display("FAIL stall_release: req=%b addr=%h want 1 00000008", mem.if_req_o, mem.if_addr_o);
        end
    endtask

    task automatic test_redirect_mid();
        branch_flag_i = 1'b1;
        branch_target_i = 32'h100;
        step();
        branch_flag_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({mem.if_req_o, mem.if_addr_o, get_inst} !== {1'b1, 32'h8, 1'b0}) begin
                errors++;
                $display("FAIL drain_addr[%0d]: req=%b addr=%h get=%b want 1 00000008 0", i, mem.if_req_o, mem.if_addr_o, get_inst);
            end
            if (i == 0) step();
        end
        mem_pulse(32'hDEAD_BEEF);
        checks++;
        if ({mem.if_req_o, mem.if_addr_o, get_inst} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL drain_done: req=%b addr=%h get=%b want 1 00000100 0", mem.if_req_o, mem.if_addr_o, get_inst);
        end
        step();
        checks++;
        if (get_inst !== 1'b0) begin
            errors++;
            $display("FAIL drain_discard: get=%b want 0", get_inst);
        end
    endtask

    task automatic test_coincident();
        mem_pulse(32'h1111_1111);
        checks++;
        if ({get_inst, if_pc, if_inst} !== {1'b1, 32'h100, 32'h1111_1111}) begin
            errors++;
            $display("FAIL target_fetch: get=%b pc=%h inst=%h want 1 00000100 11111111", get_inst, if_pc, if_inst);
        end
        step();
        branch_flag_i = 1'b1;
        branch_target_i = 32'h100;
        mem_pulse(32'h2222_2222);
        branch_flag_i = 1'b0;
        checks++;
        if ({mem.if_req_o, mem.if_addr_o, get_inst} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL coincident: req=%b addr=%h get=%b want 1 00000100 0", mem.if_req_o, mem.if_addr_o, get_inst);
        end
        mem_pulse(32'h3333_3333);
        checks++;
        if ({get_inst, if_pc, if_inst} !== {1'b1, 32'h100, 32'h3333_3333}) begin
            errors++;
            $display("FAIL coincident_refetch: get=%b pc=%h inst=%h want 1 00000100 33333333", get_inst, if_pc, if_inst);
        end
    endtask

    task automatic test_hold_redirect();
        branch_flag_i = 1'b1;
        branch_target_i = 32'h202;
        step();
        branch_flag_i = 1'b0;
        checks++;
        if ({get_inst, mem.if_req_o, mem.if_addr_o} !== {1'b0, 1'b1, 32'h200}) begin
            errors++;
            $display("FAIL hold_redirect: get=%b req=%b addr=%h want 0 1 00000200", get_inst, mem.if_req_o, mem.if_addr_o);
        end
    endtask

    task automatic test_drain_redirect();
        branch_flag_i = 1'b1;
        branch_target_i = 32'h300;
        step();
        branch_target_i = 32'h400;
        step();
        branch_flag_i = 1'b0;
        checks++;
        if ({mem.if_req_o, mem.if_addr_o} !== {1'b1, 32'h200}) begin
            errors++;
            $display("FAIL drain_second: req=%b addr=%h want 1 00000200", mem.if_req_o, mem.if_addr_o);
        end
        mem_pulse(32'h5555_5555);
        checks++;
        if ({mem.if_req_o, mem.if_addr_o, get_inst} !== {1'b1, 32'h400, 1'b0}) begin
            errors++;
            $display("FAIL drain_latest: req=%b addr=%h get=%b want 1 00000400 0", mem.if_req_o, mem.if_addr_o, get_inst);
        end
    endtask

    task automatic test_wrap();
        branch_flag_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFE;
        mem_pulse(32'h6666_6666);
        branch_flag_i = 1'b0;
        checks++;
        if (mem.if_addr_o !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_target: addr=%h want fffffffc", mem.if_addr_o);
        end
        mem_pulse(32'h4444_4444);
        checks++;
        if ({get_inst, if_pc, if_inst} !== {1'b1, 32'hFFFF_FFFC, 32'h4444_4444}) begin
            errors++;
            $display("FAIL wrap_present: get=%b pc=%h inst=%h want 1 fffffffc 44444444", get_inst, if_pc, if_inst);
        end
        step();
        checks++;
        if ({mem.if_req_o, mem.if_addr_o} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_next: req=%b addr=%h want 1 00000000", mem.if_req_o, mem.if_addr_o);
        end
    endtask

    task automatic test_reset_mid();
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({mem.if_req_o, get_inst, if_pc, if_inst, mem.if_addr_o} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid: req=%b get=%b pc=%h inst=%h addr=%h want all 0", mem.if_req_o, get_inst, if_pc, if_inst, mem.if_addr_o);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({mem.if_req_o, mem.if_addr_o} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid_restart: req=%b addr=%h want 1 00000000", mem.if_req_o, mem.if_addr_o);
        end
    endtask

    initial begin
        mem.mem_ready_i = 1'b0;
        mem.mem_inst_i  = '0;
        #1;
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_mid();
        test_coincident();
        test_hold_redirect();
        test_drain_redirect();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
